// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the register file's single write port between NREQ writeback
// requesters, such as the ALU result path, the load-return path and the CSR
// path. A round-robin valid/ready arbiter picks one requester per cycle. The
// winning write is captured in one registered output stage, which drives the
// register file's rd / write-data / write-enable inputs directly.
//
// Writes from one requester are never reordered. Writes from different
// requesters land in grant order.
//
// Parameters
//   DWIDTH       width of writeback data
//   NREQ         number of writeback requesters (2..8; 1 also works)
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous, active-high reset
//   hold_i       1 = grant nothing this cycle (pipeline freeze)
//   req_valid_i  per-requester write request
//   req_rd_i     per-requester destination register, 5 bits each
//   req_data_i   per-requester write data, DWIDTH bits each
//   req_ready_o  one-hot (or zero) grant back to the requesters
//   rd_o         register file destination register
//   datawb_o     register file write data
//   regwren_o    register file write enable (never set for x0)
//   grant_idx_o  requester whose write is currently on rd_o / datawb_o
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter  int DWIDTH = 32,
    parameter  int NREQ   = 2,
    localparam int IDXW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold_i,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*5-1:0]      req_rd_i,
    input  logic [NREQ*DWIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]        req_ready_o,
    output logic [4:0]             rd_o,
    output logic [DWIDTH-1:0]      datawb_o,
    output logic                   regwren_o,
    output logic [IDXW-1:0]        grant_idx_o
);

    logic [IDXW-1:0]   rr_ptr;
    logic [IDXW-1:0]   grant_sel;
    logic              grant_found;
    logic [4:0]        sel_rd;
    logic [DWIDTH-1:0] sel_data;

    // Requester index base+off, wrapped modulo NREQ. NREQ need not be a power
    // of two, so a plain bit-width overflow cannot do the wrap.
    function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                                 input int              off);
        int sum;
        sum = int'(base) + off;
        return IDXW'(sum % NREQ);
    endfunction

    // Round-robin grant. The search starts at rr_ptr and takes the first valid
    // requester. Reset and hold both suppress every grant, so a grant always
    // means a transfer.
    always_comb begin
        req_ready_o = '0;
        grant_found = 1'b0;
        grant_sel   = rr_ptr;
        if (!rst && !hold_i) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_found && req_valid_i[wrap_add(rr_ptr, i)]) begin
                    grant_found = 1'b1;
                    grant_sel   = wrap_add(rr_ptr, i);
                end
            end
            if (grant_found) begin
                req_ready_o[grant_sel] = 1'b1;
            end
        end
    end

    // Destination register and data of the granted requester.
    assign sel_rd   = req_rd_i[5*int'(grant_sel) +: 5];
    assign sel_data = req_data_i[DWIDTH*int'(grant_sel) +: DWIDTH];

    // Round-robin pointer. After each transfer it moves to the requester just
    // past the winner. This bounds the wait of a continuously valid requester
    // to NREQ unheld cycles. With a single requester the pointer is constant.
    generate
        if (NREQ == 1) begin : g_single
            assign rr_ptr = '0;
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    rr_ptr <= '0;
                end else if (grant_found) begin
                    rr_ptr <= wrap_add(grant_sel, 1);
                end
            end
        end
    endgenerate

    // Registered output stage. rd/data/index keep the last write so the bus
    // stays quiet between writes. Only the enable pulses. Writes to x0 are
    // accepted and then dropped here by leaving the enable low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_o        <= '0;
            datawb_o    <= '0;
            regwren_o   <= 1'b0;
            grant_idx_o <= '0;
        end else if (grant_found) begin
            rd_o        <= sel_rd;
            datawb_o    <= sel_data;
            regwren_o   <= (sel_rd != 5'd0);
            grant_idx_o <= grant_sel;
        end else begin
            regwren_o   <= 1'b0;
        end
    end

endmodule
